// File: rtl/sys_arr_pkg.sv
// Shared types for the systolic array output path: drain FSM states and default widths.
package sys_arr_pkg;

    localparam int unsigned DEF_OUTPUT_WIDTH = 32;
    localparam int unsigned DEF_NUM_ROWS     = 16;
    localparam int unsigned DEF_NUM_COLS     = 16;
    localparam int unsigned DEF_FRAME_CNT_W  = 16;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    typedef logic [DEF_OUTPUT_WIDTH-1:0] out_elem_t;

endpackage

// File: rtl/systolic_array_drain.sv
// Captures a full result matrix in one cycle and streams it out one row per beat.
// Build option SYS_ARR_DRAIN_RELU_EN: zero negative (sign-set) elements at capture.
module systolic_array_drain
    import sys_arr_pkg::*;
#(
    parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int unsigned NUM_ROWS     = DEF_NUM_ROWS,
    parameter int unsigned NUM_COLS     = DEF_NUM_COLS,
    parameter int unsigned FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
    input  logic                                              clk_i,
    input  logic                                              rst_n,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUTPUT_WIDTH-1:0] acc_i,
    input  logic                                              acc_valid_i,
    output logic                                              acc_ready_o,
    output logic [NUM_COLS-1:0][OUTPUT_WIDTH-1:0]             row_data_o,
    output logic [$clog2(NUM_ROWS)-1:0]                       row_idx_o,
    output logic                                              row_valid_o,
    output logic                                              row_last_o,
    input  logic                                              row_ready_i,
    output logic                                              busy_o,
    output logic [FRAME_CNT_W-1:0]                            frame_cnt_o
);

    localparam int unsigned     IDX_W    = $clog2(NUM_ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

    drain_state_e state;
    drain_state_e state_nxt;

    logic [IDX_W-1:0]                                   row_idx;
    logic [IDX_W-1:0]                                   row_idx_nxt;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUTPUT_WIDTH-1:0] buffer;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUTPUT_WIDTH-1:0] acc_filt;
    logic [FRAME_CNT_W-1:0]                             frame_cnt;

    logic in_drain;
    logic is_last;
    logic beat_done;
    logic frame_done;
    logic ready_int;
    logic capture;

    always_comb begin
        acc_filt = acc_i;
`ifdef SYS_ARR_DRAIN_RELU_EN
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (acc_i[r][c][OUTPUT_WIDTH-1]) begin
                    acc_filt[r][c] = '0;
                end
            end
        end
`endif
    end

    // Ready reopens during the last-row handshake so a waiting matrix lands with no bubble.
    always_comb begin
        in_drain    = (state == DRAIN);
        is_last     = in_drain && (row_idx == LAST_IDX);
        beat_done   = in_drain && row_ready_i;
        frame_done  = beat_done && is_last;
        ready_int   = !in_drain || (is_last && row_ready_i);
        capture     = acc_valid_i && ready_int;

        state_nxt   = state;
        row_idx_nxt = row_idx;

        if (capture) begin
            state_nxt   = DRAIN;
            row_idx_nxt = '0;
        end else if (frame_done) begin
            state_nxt   = IDLE;
            row_idx_nxt = '0;
        end else if (beat_done) begin
            row_idx_nxt = row_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_idx   <= '0;
            buffer    <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_idx <= row_idx_nxt;
            if (capture) begin
                buffer <= acc_filt;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Ready is held low while reset is asserted and rises as soon as it releases.
    always_comb begin
        acc_ready_o = rst_n && ready_int;
        row_data_o  = buffer[row_idx];
        row_idx_o   = row_idx;
        row_valid_o = in_drain;
        row_last_o  = is_last;
        busy_o      = in_drain;
        frame_cnt_o = frame_cnt;
    end

endmodule

// File: tb/tb_systolic_array_drain.sv
// Scoreboard bench for systolic_array_drain; expected rows are queued at capture and checked per beat.
module tb_systolic_array_drain;

    localparam int unsigned W = 32;
    localparam int unsigned R = 16;
    localparam int unsigned C = 16;
    localparam int unsigned F = 16;

    typedef logic [C*W-1:0]               wide_t;
    typedef logic [C-1:0][W-1:0]          row_t;
    typedef logic [R-1:0][C-1:0][W-1:0]   mat_t;
    typedef struct packed {
        row_t       data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic       clk_i;
    logic       rst_n;
    mat_t       acc_i;
    logic       acc_valid_i;
    logic       acc_ready_o;
    row_t       row_data_o;
    logic [3:0] row_idx_o;
    logic       row_valid_o;
    logic       row_last_o;
    logic       row_ready_i;
    logic       busy_o;
    logic [F-1:0] frame_cnt_o;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    systolic_array_drain #(
        .OUTPUT_WIDTH (W),
        .NUM_ROWS     (R),
        .NUM_COLS     (C),
        .FRAME_CNT_W  (F)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .acc_i       (acc_i),
        .acc_valid_i (acc_valid_i),
        .acc_ready_o (acc_ready_o),
        .row_data_o  (row_data_o),
        .row_idx_o   (row_idx_o),
        .row_valid_o (row_valid_o),
        .row_last_o  (row_last_o),
        .row_ready_i (row_ready_i),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected row per handshake, and checks hold-stability under stall.
    beat_t      mon_e;
    row_t       hold_data;
    logic [3:0] hold_idx;
    logic       hold_last;
    logic       stalled  = 1'b0;
    int         run      = 0;
    int         last_run = 0;

    always @(negedge clk_i) begin
        if (!rst_n) begin
            stalled = 1'b0;
            run     = 0;
        end else begin
            if (stalled && row_valid_o) begin
                chk("stall_data", wide_t'(row_data_o), wide_t'(hold_data));
                chk("stall_idx",  wide_t'(row_idx_o),  wide_t'(hold_idx));
                chk("stall_last", wide_t'(row_last_o), wide_t'(hold_last));
            end
            if (row_valid_o) begin
                run++;
            end else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
            if (row_valid_o && row_ready_i) begin
                chk("beat_expected", wide_t'(exp_q.size() != 0), wide_t'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("row_data", wide_t'(row_data_o), wide_t'(mon_e.data));
                    chk("row_idx",  wide_t'(row_idx_o),  wide_t'(mon_e.idx));
                    chk("row_last", wide_t'(row_last_o), wide_t'(mon_e.last));
                end
            end
            stalled   = row_valid_o && !row_ready_i;
            hold_data = row_data_o;
            hold_idx  = row_idx_o;
            hold_last = row_last_o;
        end
    end

    function automatic mat_t mk(input int base);
        mat_t m;
        for (int r = 0; r < int'(R); r++) begin
            for (int c = 0; c < int'(C); c++) begin
                m[r][c] = W'(base + r * 16 + c);
            end
        end
        return m;
    endfunction

    task automatic send(input mat_t m, input mat_t expm);
        beat_t b;
        int    n;
        @(posedge clk_i);
        #1;
        acc_i       = m;
        acc_valid_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        while (!acc_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("capture_timeout", wide_t'(acc_ready_o), wide_t'(1));
        for (int r = 0; r < int'(R); r++) begin
            b.data = expm[r];
            b.idx  = 4'(r);
            b.last = (r == int'(R) - 1);
            exp_q.push_back(b);
        end
        @(posedge clk_i);
        #1;
        acc_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            row_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            n++;
        end while ((busy_o || exp_q.size() != 0) && n < 2000);
        chk("drain_timeout", wide_t'(n < 2000), wide_t'(1));
        row_ready_i = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t m;
        mat_t e;
        int   n;

        rst_n       = 1'b1;
        acc_i       = '0;
        acc_valid_i = 1'b0;
        row_ready_i = 1'b1;
        #1 rst_n    = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk_i);
        chk("rst_acc_ready", wide_t'(acc_ready_o), wide_t'(0));
        chk("rst_row_valid", wide_t'(row_valid_o), wide_t'(0));
        chk("rst_row_last",  wide_t'(row_last_o),  wide_t'(0));
        chk("rst_busy",      wide_t'(busy_o),      wide_t'(0));
        chk("rst_frame_cnt", wide_t'(frame_cnt_o), wide_t'(0));
        chk("rst_row_idx",   wide_t'(row_idx_o),   wide_t'(0));
        chk("rst_row_data",  wide_t'(row_data_o),  wide_t'(0));
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_acc_ready", wide_t'(acc_ready_o), wide_t'(1));

        // 2: single matrix, no backpressure
        m = mk(0);
        send(m, m);
        wait_idle(1'b0);
        chk("single_frame_cnt", wide_t'(frame_cnt_o), wide_t'(1));
        chk("single_run_len",   wide_t'(last_run),    wide_t'(16));
        chk("single_idle_busy", wide_t'(busy_o),      wide_t'(0));

        // 3: random backpressure
        m = mk(0);
        send(m, m);
        wait_idle(1'b1);
        chk("bp_frame_cnt", wide_t'(frame_cnt_o), wide_t'(2));

        // 4: back-to-back matrices, second held until the last-row handshake
        m = mk(0);
        send(m, m);
        m = mk(1000);
        send(m, m);
        wait_idle(1'b0);
        chk("b2b_frame_cnt", wide_t'(frame_cnt_o), wide_t'(4));
        chk("b2b_run_len",   wide_t'(last_run),    wide_t'(32));

        // 5: reset during the drain at beat 7
        m = mk(3000);
        send(m, m);
        n = 0;
        while (!(row_valid_o && row_idx_o == 4'd7) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("reach_beat7", wide_t'(row_idx_o), wide_t'(7));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_row_valid", wide_t'(row_valid_o), wide_t'(0));
        chk("abort_busy",      wide_t'(busy_o),      wide_t'(0));
        chk("abort_frame_cnt", wide_t'(frame_cnt_o), wide_t'(0));
        chk("abort_row_idx",   wide_t'(row_idx_o),   wide_t'(0));
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        #2 rst_n = 1'b1;
        #1;
        chk("abort_acc_ready", wide_t'(acc_ready_o), wide_t'(1));
        m = mk(4000);
        send(m, m);
        wait_idle(1'b0);
        chk("after_abort_frame_cnt", wide_t'(frame_cnt_o), wide_t'(1));

        // 6: sign handling at capture
        m = mk(2000);
        m[0][0] = 32'hBF80_0000;
        m[0][1] = 32'h3F80_0000;
        e = m;
`ifdef SYS_ARR_DRAIN_RELU_EN
        e[0][0] = 32'h0000_0000;
`else
        e[0][0] = 32'hBF80_0000;
`endif
        send(m, e);
        wait_idle(1'b0);
        chk("relu_frame_cnt", wide_t'(frame_cnt_o), wide_t'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
